// File: rtl/io_pkg.sv
// Shared I/O-space constants and the configuration word layout for the input-port bank.
package io_pkg;

  localparam int unsigned IO_OFF_CHANGE = 8;
  localparam int unsigned IO_OFF_IRQEN  = 9;
  localparam int unsigned IO_OFF_CFG    = 10;
  localparam int unsigned IO_MAX_PORTS  = 8;
  localparam logic [5:0]  IO_BASE_SEL   = 6'b110000;

  typedef struct packed {
    logic [15:0] reserved;
    logic [7:0]  num_ports;
    logic [7:0]  width;
  } io_cfg_t;

endpackage

// File: rtl/io_input_sync.sv
// One input port: synchroniser chain, captured DATA register and change detect.
module io_input_sync #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             io_clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] data,
  output logic             change_c
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [SYNC_STAGES:0]              prime_q;
  logic [WIDTH-1:0]                  sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // prime_q fills behind the chain so reset-zeroed flops never look like an input edge
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      sync_q  <= '0;
      prime_q <= '0;
      data    <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
      prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
      data    <= sync_out;
    end
  end

  assign change_c = prime_q[SYNC_STAGES] && (sync_out != data);

endmodule

// File: rtl/io_input_bank.sv
// Memory-mapped bank of synchronised input ports with sticky change status and maskable irq.
module io_input_bank
  import io_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [5:0]  BASE_SEL    = IO_BASE_SEL
) (
  input  logic                       io_clk,
  input  logic                       resetn,
  input  logic [31:0]                addr,
  input  logic                       rd_en,
  input  logic                       wr_en,
  input  logic [31:0]                wr_data,
  input  logic [NUM_PORTS*WIDTH-1:0] in_port,
  output logic [31:0]                io_read_data,
  output logic                       irq
);

  logic [WIDTH-1:0]     port_data [NUM_PORTS];
  logic [NUM_PORTS-1:0] port_change_c;
  logic [NUM_PORTS-1:0] change_q;
  logic [NUM_PORTS-1:0] irq_en_q;
  logic [5:0]           sel_c;
  logic [5:0]           off_c;
  logic                 in_win_c;
  logic                 rd_change_c;
  logic                 wr_irqen_c;
  io_cfg_t              cfg_c;
  logic                 unused_bits;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    io_input_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .io_clk   (io_clk),
      .resetn   (resetn),
      .async_in (in_port[gi*WIDTH +: WIDTH]),
      .data     (port_data[gi]),
      .change_c (port_change_c[gi])
    );
  end

  // Word-select decode relative to the window base
  assign sel_c       = addr[7:2];
  assign off_c       = sel_c - BASE_SEL;
  assign in_win_c    = (sel_c >= BASE_SEL) && (off_c <= 6'(IO_OFF_CFG));
  assign rd_change_c = rd_en && in_win_c && (off_c == 6'(IO_OFF_CHANGE));
  assign wr_irqen_c  = wr_en && in_win_c && (off_c == 6'(IO_OFF_IRQEN));

  assign cfg_c = '{reserved: 16'h0, num_ports: 8'(NUM_PORTS), width: 8'(WIDTH)};

  assign unused_bits = ^{addr[31:8], addr[1:0], wr_data};

  // A fresh change on the read edge re-sets its bit, so set wins over clear
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      change_q <= '0;
      irq_en_q <= '0;
      irq      <= 1'b0;
    end else begin
      change_q <= (rd_change_c ? '0 : change_q) | port_change_c;
      if (wr_irqen_c) begin
        irq_en_q <= wr_data[NUM_PORTS-1:0];
      end
      irq <= |(change_q & irq_en_q);
    end
  end

  always_comb begin
    io_read_data = '0;
    if (in_win_c) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (off_c == 6'(i)) begin
          io_read_data = 32'(port_data[i]);
        end
      end
      if (off_c == 6'(IO_OFF_CHANGE)) begin
        io_read_data = 32'(change_q);
      end
      if (off_c == 6'(IO_OFF_IRQEN)) begin
        io_read_data = 32'(irq_en_q);
      end
      if (off_c == 6'(IO_OFF_CFG)) begin
        io_read_data = cfg_c;
      end
    end
  end

endmodule

// File: tb/tb_io_input_bank.sv
// Directed scoreboard bench for io_input_bank at default parameters.
module tb_io_input_bank;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned NUM_PORTS = 4;
  localparam logic [5:0]  BASE      = 6'b110000;
  localparam logic [5:0]  S_CHANGE  = BASE + 6'd8;
  localparam logic [5:0]  S_IRQEN   = BASE + 6'd9;
  localparam logic [5:0]  S_CFG     = BASE + 6'd10;

  logic                       io_clk = 1'b0;
  logic                       resetn = 1'b0;
  logic [31:0]                addr = '0;
  logic                       rd_en = 1'b0;
  logic                       wr_en = 1'b0;
  logic [31:0]                wr_data = '0;
  logic [NUM_PORTS*WIDTH-1:0] in_port = '0;
  logic [31:0]                io_read_data;
  logic                       irq;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] sb_q[$];

  io_input_bank #(
    .WIDTH       (WIDTH),
    .NUM_PORTS   (NUM_PORTS),
    .SYNC_STAGES (2),
    .BASE_SEL    (BASE)
  ) dut (
    .io_clk       (io_clk),
    .resetn       (resetn),
    .addr         (addr),
    .rd_en        (rd_en),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .in_port      (in_port),
    .io_read_data (io_read_data),
    .irq          (irq)
  );

  always #50 io_clk = ~io_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input logic [31:0] v);
    sb_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge io_clk);
      @(negedge io_clk);
    end
  endtask

  task automatic peek(input logic [5:0] sel, output logic [31:0] v);
    addr  = {24'h0, sel, 2'b00};
    rd_en = 1'b0;
    #1 v = io_read_data;
  endtask

  task automatic do_read(input logic [5:0] sel, output logic [31:0] v);
    addr  = {24'h0, sel, 2'b00};
    rd_en = 1'b1;
    #1 v = io_read_data;
    @(posedge io_clk);
    @(negedge io_clk);
    rd_en = 1'b0;
  endtask

  task automatic do_write(input logic [5:0] sel, input logic [31:0] d);
    addr    = {24'h0, sel, 2'b00};
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge io_clk);
    @(negedge io_clk);
    wr_en = 1'b0;
  endtask

  task automatic set_port(input int idx, input logic [31:0] v);
    in_port[idx*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    logic [31:0] v;

    tick(3);
    resetn = 1'b1;
    tick(4);

    // Reset state of every offset
    for (int o = 0; o <= 10; o++) begin
      push((o == 10) ? 32'h0000_0420 : 32'h0);
      peek(BASE + 6'(o), v);
      check($sformatf("rst_off%0d", o), v);
    end
    push(32'h0); check("rst_irq", 32'(irq));

    // Port 0 latency: visible two edges after the input change
    set_port(0, 32'hDEAD_BEEF);
    push(32'h0); push(32'h0); push(32'h0); push(32'hDEAD_BEEF); push(32'h1);
    tick(1); peek(BASE, v);     check("p0_k", v);
    tick(1); peek(BASE, v);     check("p0_k1", v);
             peek(S_CHANGE, v); check("chg_k1", v);
    tick(1); peek(BASE, v);     check("p0_k2", v);
             peek(S_CHANGE, v); check("chg_k2", v);
    tick(1); push(32'h0); check("irq_masked", 32'(irq));
    push(32'h1); do_read(S_CHANGE, v); check("chg_rd0", v);
    push(32'h0); peek(S_CHANGE, v);    check("chg_clr0", v);

    // Masked irq on port 1 and read-to-clear
    do_write(S_IRQEN, 32'h2);
    push(32'h2); peek(S_IRQEN, v); check("irqen_2", v);
    set_port(1, 32'h1);
    push(32'h0); push(32'h0); push(32'h0); push(32'h2); push(32'h1);
    tick(1); check("irq_k", 32'(irq));
    tick(1); check("irq_k1", 32'(irq));
    tick(1); check("irq_k2", 32'(irq));
             peek(S_CHANGE, v); check("chg_p1", v);
    tick(1); check("irq_k3", 32'(irq));
    push(32'h2); do_read(S_CHANGE, v); check("chg_rd1", v);
    push(32'h1); check("irq_hold", 32'(irq));
    push(32'h0); peek(S_CHANGE, v); check("chg_clr1", v);
    tick(1); push(32'h0); check("irq_drop", 32'(irq));

    // Set wins over read-clear on port 2
    set_port(2, 32'h5);
    tick(3);
    push(32'h4); peek(S_CHANGE, v); check("chg_p2", v);
    set_port(2, 32'h6);
    tick(2);
    push(32'h4); do_read(S_CHANGE, v); check("chg_rd2", v);
    push(32'h4); peek(S_CHANGE, v);    check("chg_setwins", v);
    push(32'h0); check("irq_p2_masked", 32'(irq));
    push(32'h4); do_read(S_CHANGE, v); check("chg_rd3", v);
    push(32'h0); peek(S_CHANGE, v);    check("chg_clr3", v);

    // Out-of-window and unmapped offsets
    push(32'h0); peek(6'b101111, v); check("below_rd", v);
    do_write(6'b101111, 32'hFFFF_FFFF);
    push(32'h0); peek(BASE + 6'd5, v); check("off5_rd", v);
    do_write(BASE + 6'd5, 32'hFFFF_FFFF);
    push(32'h0); do_read(BASE + 6'd11, v); check("off11_rd", v);
    do_write(BASE, 32'h0);
    do_write(S_CFG, 32'h0);
    do_write(S_CHANGE, 32'hFFFF_FFFF);
    push(32'h2);          peek(S_IRQEN, v);  check("irqen_kept", v);
    push(32'h0);          peek(S_CHANGE, v); check("chg_nowr", v);
    push(32'hDEAD_BEEF);  peek(BASE, v);     check("p0_nowr", v);
    push(32'h0000_0420);  peek(S_CFG, v);    check("cfg_nowr", v);
    do_write(S_IRQEN, 32'hFFFF_FFFF);
    push(32'hF); peek(S_IRQEN, v); check("irqen_mask", v);

    // Reset mid-stream
    set_port(3, 32'hA5A5_A5A5);
    tick(3);
    push(32'h8); peek(S_CHANGE, v); check("chg_p3", v);
    tick(1); push(32'h1); check("irq_p3", 32'(irq));
    set_port(0, 32'h1234_5678);
    tick(1);
    resetn = 1'b0;
    #1;
    push(32'h0); check("rst_irq_now", 32'(irq));
    push(32'h0); peek(BASE, v);           check("rst_p0_now", v);
    push(32'h0); peek(BASE + 6'd3, v);    check("rst_p3_now", v);
    push(32'h0); peek(S_CHANGE, v);       check("rst_chg_now", v);
    push(32'h0); peek(S_IRQEN, v);        check("rst_irqen_now", v);
    set_port(1, 32'hCAFE_F00D);
    tick(1);
    set_port(2, 32'h0BAD_F00D);
    tick(1);
    resetn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick(1);
      push(32'h0); peek(S_CHANGE, v); check($sformatf("rel_chg%0d", c), v);
    end
    push(32'h0BAD_F00D); peek(BASE + 6'd2, v); check("rel_p2", v);
    push(32'h1234_5678); peek(BASE, v);        check("rel_p0", v);
    push(32'h0); check("rel_irq", 32'(irq));
    set_port(2, 32'h0BAD_F00E);
    tick(3);
    push(32'h4); peek(S_CHANGE, v); check("rel_newedge", v);

    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_drain observed=%0d expected=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
